alu_acc: RTL and testbench

- Parametrised accumulator ALU. It combines operand `a` with the low half of its own result register and writes the outcome back into that register.
- Successor to the 4-bit lab ALU/register pair. Width is generic, ADD and SUB produce a carry/borrow flag, and multiply is a multi-cycle shift-add unit.
- A start/busy/done handshake replaces the free-running register load.
- Sits between the switch/key input conditioning and the hex display drivers; `result` feeds the LEDR and HEX outputs directly.

---
 rtl/alu_acc_pkg.sv | 24 ++
 rtl/alu_acc_if.sv | 32 +++
 rtl/shift_add_mul.sv | 88 ++++++++
 rtl/alu_acc.sv | 115 +++++++++++
 tb/tb_alu_acc.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_acc_pkg
// Description : Op codes and multiplier state encoding for the accumulator ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_acc_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_LOGIC = 3'd2;
    localparam logic [2:0] OP_ANY   = 3'd3;
    localparam logic [2:0] OP_ALL   = 3'd4;
    localparam logic [2:0] OP_SHL   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;
    localparam logic [2:0] OP_HOLD  = 3'd7;

    typedef enum logic [0:0] {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_acc_if
// Description : Request/response bundle between the accumulator ALU and its
//               driver (start/op/a in, busy/done/result/flags out).
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_acc_if #(
    parameter int W = 4
) ();

    logic             start;
    logic [2:0]       op;
    logic [W-1:0]     a;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;
    logic             carry;
    logic             zero;

    modport master (
        output start, op, a,
        input  busy, done, result, carry, zero
    );

    modport slave (
        input  start, op, a,
        output busy, done, result, carry, zero
    );

endinterface
`default_nettype wire

// File: rtl/shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mul
// Description : W-cycle unsigned shift-add multiplier. product is the value the
//               accumulator takes on the edge where done is high.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mul
    import alu_acc_pkg::*;
#(
    parameter int W = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             go,
    input  wire logic [W-1:0]     a,
    input  wire logic [W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*W-1:0]        product
);

    localparam int c_cnt_w = (W > 1) ? $clog2(W) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(W - 1);

    mul_state_e           r_state_q,  w_state_d;
    logic [c_cnt_w-1:0]   r_cnt_q,    w_cnt_d;
    logic [2*W-1:0]       r_mcand_q,  w_mcand_d;
    logic [W-1:0]         r_mplier_q, w_mplier_d;
    logic [2*W-1:0]       r_acc_q,    w_acc_d;
    logic [2*W-1:0]       w_acc_step;

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_mcand_d  = r_mcand_q;
        w_mplier_d = r_mplier_q;
        w_acc_d    = r_acc_q;
        done       = 1'b0;
        w_acc_step = r_mplier_q[0] ? (r_acc_q + r_mcand_q) : r_acc_q;

        case (r_state_q)
            MUL_IDLE: begin
                if (go) begin
                    w_state_d  = MUL_RUN;
                    w_cnt_d    = '0;
                    w_mcand_d  = {{W{1'b0}}, a};
                    w_mplier_d = b;
                    w_acc_d    = '0;
                end
            end
            MUL_RUN: begin
                w_acc_d    = w_acc_step;
                w_mcand_d  = {r_mcand_q[2*W-2:0], 1'b0};
                w_mplier_d = {1'b0, r_mplier_q[W-1:1]};
                w_cnt_d    = r_cnt_q + 1'b1;
                // Last iteration: hand the finished sum straight to the caller
                // so it lands in the accumulator on this same edge.
                if (r_cnt_q == c_cnt_last) begin
                    w_state_d = MUL_IDLE;
                    done      = 1'b1;
                end
            end
            default: w_state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q  <= MUL_IDLE;
            r_cnt_q    <= '0;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_acc_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_mcand_q  <= w_mcand_d;
            r_mplier_q <= w_mplier_d;
            r_acc_q    <= w_acc_d;
        end
    end

    assign busy    = (r_state_q == MUL_RUN);
    assign product = w_acc_step;

endmodule
`default_nettype wire

// File: rtl/alu_acc.sv
`default_nettype none
// ============================================================================
// Module      : alu_acc
// Description : Accumulator ALU: combines operand a with the low half of its
//               own 2*W-bit result register; MUL runs on a shift-add unit.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_acc
    import alu_acc_pkg::*;
#(
    parameter int W = 4
) (
    input  wire logic   clock,
    input  wire logic   reset,
    alu_acc_if.slave    bus
);

    localparam int SHW = $clog2(2 * W);
    localparam logic [2*W-1:0] c_any_set = {1'b1, {(2*W-2){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] c_all_set = {1'b0, {(2*W-2){1'b1}}, 1'b0};

    logic [2*W-1:0]  r_result_q, w_result_d;
    logic            r_carry_q,  w_carry_d;
    logic            r_done_q,   w_done_d;

    logic [W-1:0]    w_b;
    logic [SHW-1:0]  w_sh;
    logic [W:0]      w_sum;
    logic [W:0]      w_diff;
    logic [2*W-1:0]  w_shl;
    logic            w_accept;
    logic            w_go;
    logic            w_mul_busy;
    logic            w_mul_done;
    logic [2*W-1:0]  w_mul_product;

    shift_add_mul #(
        .W (W)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .go      (w_go),
        .a       (bus.a),
        .b       (w_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    always_comb begin
        w_b        = r_result_q[W-1:0];
        w_sh       = r_result_q[SHW-1:0];
        w_sum      = {1'b0, bus.a} + {1'b0, w_b};
        // Borrow falls out as bit W of the widened difference.
        w_diff     = {1'b0, w_b} - {1'b0, bus.a};
        w_shl      = {{W{1'b0}}, bus.a} << w_sh;
        w_accept   = bus.start && !w_mul_busy;

        w_result_d = r_result_q;
        w_carry_d  = r_carry_q;
        w_done_d   = 1'b0;
        w_go       = 1'b0;

        if (w_mul_done) begin
            w_result_d = w_mul_product;
            w_carry_d  = 1'b0;
            w_done_d   = 1'b1;
        end else if (w_accept) begin
            w_carry_d = 1'b0;
            w_done_d  = 1'b1;
            case (bus.op)
                OP_ADD: begin
                    w_result_d = {{(W-1){1'b0}}, w_sum};
                    w_carry_d  = w_sum[W];
                end
                OP_SUB: begin
                    w_result_d = {{W{1'b0}}, w_diff[W-1:0]};
                    w_carry_d  = w_diff[W];
                end
                OP_LOGIC: w_result_d = {bus.a ^ w_b, bus.a | w_b};
                OP_ANY:   w_result_d = (|bus.a) ? c_any_set : '0;
                OP_ALL:   w_result_d = (&bus.a) ? c_all_set : '0;
                OP_SHL:   w_result_d = w_shl;
                OP_MUL: begin
                    // Completion is reported later by the multiplier.
                    w_go      = 1'b1;
                    w_done_d  = 1'b0;
                    w_carry_d = r_carry_q;
                end
                OP_HOLD:  w_result_d = r_result_q;
                default:  w_result_d = r_result_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_result_q <= '0;
            r_carry_q  <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_result_q <= w_result_d;
            r_carry_q  <= w_carry_d;
            r_done_q   <= w_done_d;
        end
    end

    assign bus.busy   = w_mul_busy;
    assign bus.done   = r_done_q;
    assign bus.result = r_result_q;
    assign bus.carry  = r_carry_q;
    assign bus.zero   = (r_result_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_acc
// Description : Directed plus randomized bench for alu_acc against an
//               arithmetic reference model of the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_acc;
    import alu_acc_pkg::*;

    localparam int W   = 4;
    localparam int SHW = $clog2(2 * W);
    localparam longint MOD_W  = longint'(1) << W;
    localparam longint MOD_2W = longint'(1) << (2 * W);

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    longint m_res   = 0;
    logic   m_carry = 1'b0;

    alu_acc_if #(.W(W)) bus ();

    alu_acc #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the accumulator's next value computed with plain arithmetic.
    task automatic model_op(input int op, input longint av);
        longint b;
        longint s;
        b = m_res % MOD_W;
        m_carry = 1'b0;
        case (op)
            0: begin s = av + b; m_res = s; m_carry = (s >= MOD_W); end
            1: begin m_res = (b - av + MOD_W) % MOD_W; m_carry = (av > b); end
            2: m_res = ((av ^ b) * MOD_W) + (av | b);
            3: m_res = (av != 0) ? (MOD_2W / 2 + 1) : 0;
            4: m_res = (av == MOD_W - 1) ? (MOD_2W / 2 - 2) : 0;
            5: m_res = (av * (longint'(1) << (m_res % (longint'(1) << SHW)))) % MOD_2W;
            6: m_res = av * b;
            default: ;
        endcase
    endtask

    task automatic check_state(input string tag);
        check({tag, "_result"}, 64'(bus.result), 64'(m_res));
        check({tag, "_carry"},  64'(bus.carry),  64'(m_carry));
        check({tag, "_zero"},   64'(bus.zero),   64'(m_res == 0));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        m_res = 0;
        m_carry = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check_state("rst");
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input bit intrude);
        longint old;
        int     busy_cycles;
        int     guard;
        old = m_res;
        model_op(int'(op), longint'(av));
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = av;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = W'($urandom);
        if (op != OP_MUL) begin
            check("op_done", 64'(bus.done), 64'd1);
            check("op_busy", 64'(bus.busy), 64'd0);
            check_state("op");
        end else begin
            check("mul_busy_start", 64'(bus.busy), 64'd1);
            check("mul_done_start", 64'(bus.done), 64'd0);
            check("mul_hold_start", 64'(bus.result), 64'(old));
            if (intrude) begin
                bus.start = 1'b1;
                bus.op    = OP_ADD;
                bus.a     = W'($urandom);
            end
            busy_cycles = 1;
            guard = 0;
            while (bus.busy && guard < 4 * W) begin
                @(posedge clock);
                #1;
                guard++;
                if (bus.busy) begin
                    busy_cycles++;
                    check("mul_hold", 64'(bus.result), 64'(old));
                    check("mul_done_early", 64'(bus.done), 64'd0);
                end
            end
            bus.start = 1'b0;
            check("mul_busy_len", 64'(busy_cycles), 64'(W));
            check("mul_done", 64'(bus.done), 64'd1);
            check_state("mul");
        end
        @(posedge clock);
        #1;
        check("done_drop", 64'(bus.done), 64'd0);
        check("quiet_result", 64'(bus.result), 64'(m_res));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_HOLD;
        bus.a     = '0;

        // 1: ADD with carry
        do_reset();
        run_op(OP_ADD, 4'h9, 1'b0);
        check("p1_res", 64'(bus.result), 64'h09);
        check("p1_c",   64'(bus.carry),  64'd0);
        run_op(OP_ADD, 4'h9, 1'b0);
        check("p1b_res", 64'(bus.result), 64'h12);
        check("p1b_c",   64'(bus.carry),  64'd1);

        // 2: SUB with borrow, then to zero
        do_reset();
        run_op(OP_ADD, 4'h5, 1'b0);
        run_op(OP_SUB, 4'h7, 1'b0);
        check("p2_res", 64'(bus.result), 64'h0E);
        check("p2_c",   64'(bus.carry),  64'd1);
        run_op(OP_SUB, 4'hE, 1'b0);
        check("p2b_res", 64'(bus.result), 64'h00);
        check("p2b_z",   64'(bus.zero),   64'd1);
        check("p2b_c",   64'(bus.carry),  64'd0);

        // 3: LOGIC / ANY / ALL
        do_reset();
        run_op(OP_ADD, 4'h3, 1'b0);
        run_op(OP_LOGIC, 4'h5, 1'b0);
        check("p3_logic", 64'(bus.result), 64'h67);
        run_op(OP_ANY, 4'h0, 1'b0);
        check("p3_any0", 64'(bus.result), 64'h00);
        run_op(OP_ANY, 4'h2, 1'b0);
        check("p3_any2", 64'(bus.result), 64'h81);
        run_op(OP_ALL, 4'hF, 1'b0);
        check("p3_allF", 64'(bus.result), 64'h7E);
        run_op(OP_ALL, 4'hE, 1'b0);
        check("p3_allE", 64'(bus.result), 64'h00);

        // 4: SHL including bits shifted out
        do_reset();
        run_op(OP_ADD, 4'h3, 1'b0);
        run_op(OP_SHL, 4'hB, 1'b0);
        check("p4_shl3", 64'(bus.result), 64'h58);
        do_reset();
        run_op(OP_ADD, 4'h7, 1'b0);
        run_op(OP_SHL, 4'hF, 1'b0);
        check("p4_shl7", 64'(bus.result), 64'h80);

        // 5: MUL with an ADD request held across busy and the completion edge
        do_reset();
        run_op(OP_ADD, 4'hD, 1'b0);
        run_op(OP_MUL, 4'hB, 1'b1);
        check("p5_mul", 64'(bus.result), 64'h8F);

        // 6: reset two cycles into a MUL
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 4'h7;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        check("p6_busy", 64'(bus.busy), 64'd1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        m_res = 0;
        m_carry = 1'b0;
        check("p6_rst_busy", 64'(bus.busy), 64'd0);
        check("p6_rst_done", 64'(bus.done), 64'd0);
        check_state("p6_rst");
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < W + 1; i++) begin
            @(posedge clock);
            #1;
            check("p6_no_done", 64'(bus.done), 64'd0);
            check("p6_stay0", 64'(bus.result), 64'd0);
        end
        run_op(OP_ADD, 4'h1, 1'b0);
        check("p6_add", 64'(bus.result), 64'h01);

        // Back-to-back: start held high launches an ADD on every edge
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = OP_ADD;
        for (int i = 0; i < 4; i++) begin
            bus.a = W'($urandom);
            model_op(0, longint'(bus.a));
            @(posedge clock);
            #1;
            check("b2b_done", 64'(bus.done), 64'd1);
            check_state("b2b");
        end
        bus.start = 1'b0;
        @(posedge clock);
        #1;

        // Randomized sequence against the reference model
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                do_reset();
            end else begin
                run_op(3'($urandom_range(0, 7)), W'($urandom), 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
